// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths, width helpers.
// Pure declarations; no timing or flow-control behaviour of its own.
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;

    typedef logic [1:0] apb_state_t;

    localparam apb_state_t ST_IDLE   = 2'd0;
    localparam apb_state_t ST_SETUP  = 2'd1;
    localparam apb_state_t ST_ACCESS = 2'd2;
    localparam apb_state_t ST_RESP   = 2'd3;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // A counter must hold 0..limit, and needs at least one bit even when limit is 0.
    function automatic int cnt_width(input int limit);
        int w;
        w = clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// Wait-state counter: clears synchronously, counts enabled cycles, saturates at all-ones.
// expired is decoded from the count register (no input-to-output path); limit 0 never expires.
module apb_timeout_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (limit != '0) && (count_q == limit);

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 initiator: command accept -> SETUP -> ACCESS (wait/timeout) -> RESP.
// Response visible 3 cycles after accept plus wait states; cmd_ready is low until RESP is handshaken.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = APB_DATA_WIDTH,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  M_PSEL,
    output logic                  M_PENABLE,
    output logic                  M_PWRITE,
    output logic [ADDR_WIDTH-1:0] M_PADDR,
    output logic [DATA_WIDTH-1:0] M_PWDATA,
    input  logic                  M_PREADY,
    input  logic                  M_PSLVERR,
    input  logic [DATA_WIDTH-1:0] M_PRDATA
);

    localparam int                CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    apb_state_t state_q;
    apb_state_t state_d;

    // Keeps cmd_ready low during reset even though the state already reads IDLE.
    logic                  out_of_reset_q;

    logic [ADDR_WIDTH-1:0] paddr_q;
    logic                  pwrite_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  tmo_q;

    logic                  accept;
    logic                  xfer_done;
    logic                  xfer_tmo;
    logic                  wait_expired;

    assign accept    = cmd_valid && cmd_ready;
    assign xfer_done = (state_q == ST_ACCESS) && M_PREADY;
    assign xfer_tmo  = (state_q == ST_ACCESS) && !M_PREADY && wait_expired;

    apb_timeout_counter #(
        .WIDTH (CNT_W)
    ) u_wait_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .enable  ((state_q == ST_ACCESS) && !M_PREADY),
        .limit   (LIMIT),
        .expired (wait_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            out_of_reset_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            out_of_reset_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (accept) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (xfer_done || xfer_tmo) state_d = ST_RESP;
            ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        M_PSEL    = 1'b0;
        M_PENABLE = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            ST_IDLE:   cmd_ready = out_of_reset_q;
            ST_SETUP:  M_PSEL = 1'b1;
            ST_ACCESS: begin
                M_PSEL    = 1'b1;
                M_PENABLE = 1'b1;
            end
            ST_RESP:   rsp_valid = 1'b1;
            default:   cmd_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            if (accept) begin
                paddr_q  <= cmd_addr;
                pwrite_q <= cmd_write;
                pwdata_q <= cmd_wdata;
            end
            if (xfer_done) begin
                rdata_q <= pwrite_q ? '0 : M_PRDATA;
                err_q   <= M_PSLVERR;
                tmo_q   <= 1'b0;
            end else if (xfer_tmo) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
                tmo_q   <= 1'b1;
            end
        end
    end

    assign M_PADDR     = paddr_q;
    assign M_PWRITE    = pwrite_q;
    assign M_PWDATA    = pwdata_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = tmo_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge (TIMEOUT = 4) with a programmable wait-state APB slave.
module tb_apb_master_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        M_PSEL;
    logic        M_PENABLE;
    logic        M_PWRITE;
    logic [31:0] M_PADDR;
    logic [31:0] M_PWDATA;
    logic        M_PREADY;
    logic        M_PSLVERR;
    logic [31:0] M_PRDATA;

    int checks = 0;
    int passed = 0;

    // Slave model: ready after slv_wait ACCESS cycles; garbage data/error while not ready.
    logic        slv_never = 1'b0;
    logic        slv_err   = 1'b0;
    int          slv_wait  = 0;
    logic [31:0] slv_rdata = 32'h0;
    logic [7:0]  acc_cnt;

    always @(posedge clk) acc_cnt <= (M_PSEL && M_PENABLE) ? acc_cnt + 8'd1 : 8'd0;

    assign M_PREADY  = !slv_never && M_PSEL && M_PENABLE && (int'(acc_cnt) == slv_wait);
    assign M_PRDATA  = M_PREADY ? slv_rdata : 32'hBAD0_BAD0;
    assign M_PSLVERR = M_PREADY ? slv_err : 1'b1;

    always #5 clk = ~clk;

    apb_master_bridge #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .M_PSEL      (M_PSEL),
        .M_PENABLE   (M_PENABLE),
        .M_PWRITE    (M_PWRITE),
        .M_PADDR     (M_PADDR),
        .M_PWDATA    (M_PWDATA),
        .M_PREADY    (M_PREADY),
        .M_PSLVERR   (M_PSLVERR),
        .M_PRDATA    (M_PRDATA)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one command for a single edge (caller ensures cmd_ready is high).
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Called in cycle N+1; returns k such that rsp_valid first seen in cycle N+k (bounded).
    task automatic wait_rsp(output int n, output logic stable);
        logic [31:0] a0;
        logic [31:0] d0;
        logic        w0;
        a0 = M_PADDR;
        d0 = M_PWDATA;
        w0 = M_PWRITE;
        stable = 1'b1;
        n = 1;
        while (!rsp_valid && n < 40) begin
            if (M_PSEL && (M_PADDR !== a0 || M_PWDATA !== d0 || M_PWRITE !== w0)) stable = 1'b0;
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({cmd_ready, rsp_valid, rsp_err, rsp_timeout, M_PSEL, M_PENABLE, M_PWRITE} !== 7'b0 ||
            M_PADDR !== 32'h0 || M_PWDATA !== 32'h0 || rsp_rdata !== 32'h0)
            $display("FAIL reset_outputs: ctl=%b paddr=%h pwdata=%h rdata=%h, required all zero",
                     {cmd_ready, rsp_valid, rsp_err, rsp_timeout, M_PSEL, M_PENABLE, M_PWRITE},
                     M_PADDR, M_PWDATA, rsp_rdata);
        else passed++;
        rst = 1'b1;
        checks++;
        if (cmd_ready !== 1'b0) $display("FAIL reset_release_ready_early: got %b want 0", cmd_ready);
        else passed++;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
        else passed++;
    endtask

    task automatic test_write();
        int   n;
        logic st;
        slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'hDEAD_BEEF;
        issue(1'b1, 32'h0000_0004, 32'h0000_005A);
        checks++;
        if ({M_PSEL, M_PENABLE, M_PWRITE, cmd_ready, rsp_valid} !== 5'b10100 ||
            M_PADDR !== 32'h4 || M_PWDATA !== 32'h5A)
            $display("FAIL write_setup: sel/en/wr/rdy/rv=%b paddr=%h pwdata=%h, required 10100 4 5a",
                     {M_PSEL, M_PENABLE, M_PWRITE, cmd_ready, rsp_valid}, M_PADDR, M_PWDATA);
        else passed++;
        tick();
        checks++;
        if ({M_PSEL, M_PENABLE, rsp_valid} !== 3'b110)
            $display("FAIL write_access: sel/en/rv=%b required 110", {M_PSEL, M_PENABLE, rsp_valid});
        else passed++;
        wait_rsp(n, st);
        n = n + 1;
        checks++;
        if (n !== 3) $display("FAIL write_latency: rsp_valid at N+%0d required N+3", n);
        else passed++;
        checks++;
        if ({M_PSEL, M_PENABLE, rsp_err, rsp_timeout} !== 4'b0 || rsp_rdata !== 32'h0)
            $display("FAIL write_rsp: sel/en/err/tmo=%b rdata=%h required 0000 0",
                     {M_PSEL, M_PENABLE, rsp_err, rsp_timeout}, rsp_rdata);
        else passed++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01)
            $display("FAIL write_handshake: rv/rdy=%b required 01", {rsp_valid, cmd_ready});
        else passed++;
    endtask

    task automatic test_read_wait();
        int   n;
        logic st;
        slv_wait = 3; slv_err = 1'b0; slv_rdata = 32'h0000_1C2A;
        issue(1'b0, 32'h0000_000C, 32'hFFFF_FFFF);
        wait_rsp(n, st);
        checks++;
        if (n !== 6) $display("FAIL read_wait_latency: rsp_valid at N+%0d required N+6", n);
        else passed++;
        checks++;
        if (st !== 1'b1 || M_PADDR !== 32'hC)
            $display("FAIL read_wait_paddr_stable: stable=%b paddr=%h required 1 c", st, M_PADDR);
        else passed++;
        checks++;
        if (rsp_rdata !== 32'h0000_1C2A || rsp_err !== 1'b0 || rsp_timeout !== 1'b0)
            $display("FAIL read_wait_rsp: rdata=%h err=%b tmo=%b required 00001c2a 0 0",
                     rsp_rdata, rsp_err, rsp_timeout);
        else passed++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_slverr();
        int   n;
        logic st;
        slv_wait = 0; slv_err = 1'b1; slv_rdata = 32'h1234_0000;
        issue(1'b1, 32'h0000_0010, 32'h0000_0099);
        wait_rsp(n, st);
        checks++;
        if (n !== 3 || rsp_err !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0)
            $display("FAIL slverr_rsp: lat=%0d err=%b tmo=%b rdata=%h required 3 1 0 0",
                     n, rsp_err, rsp_timeout, rsp_rdata);
        else passed++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        slv_err = 1'b0;
    endtask

    task automatic test_timeout();
        int   n;
        logic st;
        slv_never = 1'b1; slv_rdata = 32'h5555_AAAA;
        issue(1'b0, 32'h0000_0018, 32'h0);
        wait_rsp(n, st);
        checks++;
        if (n !== 7) $display("FAIL timeout_latency: rsp_valid at N+%0d required N+7", n);
        else passed++;
        checks++;
        if ({M_PSEL, M_PENABLE, rsp_err, rsp_timeout} !== 4'b0011 || rsp_rdata !== 32'h0)
            $display("FAIL timeout_rsp: sel/en/err/tmo=%b rdata=%h required 0011 0",
                     {M_PSEL, M_PENABLE, rsp_err, rsp_timeout}, rsp_rdata);
        else passed++;
        slv_never = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int   n;
        logic st;
        logic held_ok;
        slv_wait = 1; slv_rdata = 32'h1234_5678;
        issue(1'b0, 32'h0000_0020, 32'h0);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0024; cmd_wdata = 32'h0000_0077;
        wait_rsp(n, st);
        checks++;
        if (n !== 4) $display("FAIL b2b_first_latency: rsp_valid at N+%0d required N+4", n);
        else passed++;
        held_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || M_PSEL !== 1'b0 ||
                rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0) held_ok = 1'b0;
            tick();
        end
        checks++;
        if (held_ok !== 1'b1 || rsp_rdata !== 32'h1234_5678)
            $display("FAIL b2b_rsp_hold: held_ok=%b rdata=%h required 1 12345678", held_ok, rsp_rdata);
        else passed++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready, M_PSEL} !== 3'b010)
            $display("FAIL b2b_after_handshake: rv/rdy/sel=%b required 010", {rsp_valid, cmd_ready, M_PSEL});
        else passed++;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({M_PSEL, M_PENABLE, M_PWRITE} !== 3'b101 || M_PADDR !== 32'h24 || M_PWDATA !== 32'h77)
            $display("FAIL b2b_second_accept: sel/en/wr=%b paddr=%h pwdata=%h required 101 24 77",
                     {M_PSEL, M_PENABLE, M_PWRITE}, M_PADDR, M_PWDATA);
        else passed++;
        slv_wait = 0;
        wait_rsp(n, st);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int   n;
        logic st;
        slv_never = 1'b1;
        issue(1'b1, 32'h0000_0008, 32'h0000_00F0);
        tick();
        checks++;
        if ({M_PSEL, M_PENABLE} !== 2'b11)
            $display("FAIL midrst_in_access: sel/en=%b required 11", {M_PSEL, M_PENABLE});
        else passed++;
        rst = 1'b0;
        tick();
        checks++;
        if ({M_PSEL, M_PENABLE, rsp_valid, cmd_ready} !== 4'b0 || M_PADDR !== 32'h0)
            $display("FAIL midrst_abort: sel/en/rv/rdy=%b paddr=%h required 0000 0",
                     {M_PSEL, M_PENABLE, rsp_valid, cmd_ready}, M_PADDR);
        else passed++;
        rst = 1'b1;
        slv_never = 1'b0; slv_wait = 0; slv_rdata = 32'hCAFE_0001;
        tick();
        checks++;
        if ({cmd_ready, rsp_valid} !== 2'b10)
            $display("FAIL midrst_release: rdy/rv=%b required 10", {cmd_ready, rsp_valid});
        else passed++;
        issue(1'b0, 32'h0000_0000, 32'h0);
        wait_rsp(n, st);
        checks++;
        if (n !== 3 || rsp_rdata !== 32'hCAFE_0001 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0)
            $display("FAIL midrst_read: lat=%0d rdata=%h err=%b tmo=%b required 3 cafe0001 0 0",
                     n, rsp_rdata, rsp_err, rsp_timeout);
        else passed++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        rsp_ready = 1'b0;
        #1;
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
